// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the iterative multiply/divide unit.
//   md_op_t    - operation select encoding driven on md_op
//   md_state_t - sequencer states of mul_div_unit
//   MD_ITER    - number of iteration cycles per operation
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/result bundle between the core and mul_div_unit.
//   start, md_op, src_a, src_b     - operation launch and operands
//   hi_we, lo_we, wr_data          - MTHI/MTLO writes
//   busy, done, hi, lo             - status and architectural HI/LO
// master = core side (drives requests), slave = mul_div_unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  import md_pkg::*;

  logic             start;
  md_op_t           md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, src_a, src_b, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division step.
//   rem_in   - partial remainder (always < divisor on entry)
//   quo_in   - quotient register; its MSB is the next dividend bit
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after this step
//   quo_out  - quotient shifted left with the new quotient bit in bit 0
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift the next dividend bit into the remainder, then subtract the
  // divisor only if it fits (restoring = keep the shifted value otherwise).
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor}) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-cycle multiply/divide unit with HI/LO registers.
//   clk, rst  - core clock, synchronous active-high reset
//   bus       - mul_div_unit_if.slave: start/md_op/src_a/src_b launch an
//               operation, hi_we/lo_we/wr_data implement MTHI/MTLO,
//               busy/done/hi/lo are registered status and results.
// Signed operations run on operand magnitudes; the sign is restored when
// the final step writes HI/LO.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MD_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_final;
  logic [WIDTH-1:0]   rem_final;

  // The divider shares acc: upper half holds the partial remainder and the
  // lower half starts as the dividend and fills with quotient bits.
  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc[2*WIDTH-1:WIDTH]),
    .quo_in  (acc[WIDTH-1:0]),
    .divisor (operand),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // Operand magnitudes at launch, plus the shift-add multiply step: the
  // multiplier sits in the low half of acc and is consumed LSB first while
  // the product grows in from the top.
  always_comb begin
    signed_op  = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
    a_neg      = signed_op && bus.src_a[WIDTH-1];
    b_neg      = signed_op && bus.src_b[WIDTH-1];
    mag_a      = a_neg ? -bus.src_a : bus.src_a;
    mag_b      = b_neg ? -bus.src_b : bus.src_b;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                 (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    mul_next   = {mul_sum, acc[WIDTH-1:1]};
    prod_final = neg_res ? -mul_next : mul_next;
    quo_final  = neg_res ? -quo_next : quo_next;
    rem_final  = neg_rem ? -rem_next : rem_next;
  end

  // Sequencer: launch latches magnitudes and sign info, CALC iterates one
  // step per cycle and the last step writes the sign-corrected result.
  // MTHI/MTLO are accepted whenever no operation is in flight, including in
  // the launch cycle; a later result simply overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (state != CALC) begin
        if (bus.hi_we) hi_q <= bus.wr_data;
        if (bus.lo_we) lo_q <= bus.wr_data;
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= CALC;
            cnt      <= '0;
            busy_q   <= 1'b1;
            is_div   <= bus.md_op[1];
            a_raw    <= bus.src_a;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= bus.md_op[1] && (bus.src_b == '0);
            acc      <= bus.md_op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            operand  <= bus.md_op[1] ? mag_b : mag_a;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= is_div ? {rem_next, quo_next} : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (!is_div) begin
              hi_q <= prod_final[2*WIDTH-1:WIDTH];
              lo_q <= prod_final[WIDTH-1:0];
            end else if (div_zero) begin
              hi_q <= a_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_final;
              lo_q <= quo_final;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
